// File: rtl/mips_bus_pkg.sv
// Shared encodings for the CPU-to-Avalon load/store bridge: access sizes,
// controller states and the lane-qualification helpers.
package mips_bus_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUS  = 2'b01,
        RESP = 2'b10
    } state_e;

    // The reserved size code is reported as an error, just like a misaligned address.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = offset[0];
            SZ_WORD: bad = (offset != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] offset);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << offset;
            SZ_HALF: be = 4'b0011 << offset;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/byte_lane_align.sv
// Little-endian lane steering: replicates store data across lanes, or pulls a
// load lane down to bit 0 with optional sign extension.
module byte_lane_align
    import mips_bus_pkg::*;
(
    input  logic        load_mode,
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        sign_ext,
    input  logic [31:0] data_in,
    output logic [31:0] data_out
);

    logic [31:0] shifted;

    always_comb begin
        shifted  = data_in >> {offset, 3'b000};
        data_out = data_in;
        if (load_mode) begin
            case (size)
                SZ_BYTE: data_out = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
                SZ_HALF: data_out = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
                default: data_out = data_in;
            endcase
        end else begin
            // Replication lets the slave pick the active lanes via byteenable alone.
            case (size)
                SZ_BYTE: data_out = {4{data_in[7:0]}};
                SZ_HALF: data_out = {2{data_in[15:0]}};
                default: data_out = data_in;
            endcase
        end
    end

endmodule

// File: rtl/bus_interface.sv
// Single-outstanding bridge from the CPU load/store request port to an
// Avalon-MM master; all bus and response outputs are registered.
module bus_interface
    import mips_bus_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata,
    input  logic        waitrequest,
    input  logic [31:0] readdata
);

    state_e      state;
    logic [1:0]  offset_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic        write_q;
    logic [31:0] store_data;
    logic [31:0] load_data;

    byte_lane_align u_store_align (
        .load_mode (1'b0),
        .size      (req_size),
        .offset    (req_addr[1:0]),
        .sign_ext  (1'b0),
        .data_in   (req_wdata),
        .data_out  (store_data)
    );

    byte_lane_align u_load_align (
        .load_mode (1'b1),
        .size      (size_q),
        .offset    (offset_q),
        .sign_ext  (signed_q),
        .data_in   (readdata),
        .data_out  (load_data)
    );

    assign req_ready = (state == IDLE);

    // Bus outputs are loaded at acceptance so they are valid for the whole BUS
    // state, and held untouched while the slave stalls with waitrequest.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            offset_q   <= 2'b00;
            size_q     <= SZ_BYTE;
            signed_q   <= 1'b0;
            write_q    <= 1'b0;
            address    <= 32'h0;
            read       <= 1'b0;
            write      <= 1'b0;
            byteenable <= 4'h0;
            writedata  <= 32'h0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_data  <= 32'h0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        offset_q <= req_addr[1:0];
                        size_q   <= req_size;
                        signed_q <= req_signed;
                        write_q  <= req_write;
                        if (is_misaligned(req_size, req_addr[1:0])) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_data  <= 32'h0;
                        end else begin
                            state      <= BUS;
                            address    <= {req_addr[31:2], 2'b00};
                            read       <= ~req_write;
                            write      <= req_write;
                            byteenable <= byte_enable(req_size, req_addr[1:0]);
                            writedata  <= store_data;
                        end
                    end
                end
                BUS: begin
                    if (!waitrequest) begin
                        state      <= RESP;
                        read       <= 1'b0;
                        write      <= 1'b0;
                        byteenable <= 4'h0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_data  <= write_q ? 32'h0 : load_data;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_interface.sv
// Directed-vector bench for bus_interface: aligned loads/stores, wait states,
// misaligned rejection and reset in the middle of a bus cycle.
module tb_bus_interface;

    logic        clk;
    logic        reset;
    logic        reqValid;
    logic        reqWrite;
    logic [31:0] reqAddr;
    logic [1:0]  reqSize;
    logic        reqSigned;
    logic [31:0] reqWdata;
    logic        reqReady;
    logic        respValid;
    logic [31:0] respData;
    logic        respErr;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic        waitrequest;
    logic [31:0] readdata;

    int checkCount;
    int errorCount;

    bus_interface dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (reqValid),
        .req_write   (reqWrite),
        .req_addr    (reqAddr),
        .req_size    (reqSize),
        .req_signed  (reqSigned),
        .req_wdata   (reqWdata),
        .req_ready   (reqReady),
        .resp_valid  (respValid),
        .resp_data   (respData),
        .resp_err    (respErr),
        .address     (address),
        .read        (read),
        .write       (write),
        .byteenable  (byteenable),
        .writedata   (writedata),
        .waitrequest (waitrequest),
        .readdata    (readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout required completion");
        $fatal(1, "[TB] simulation did not finish");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %h required %h", tag, observed, expected);
        end
    endtask

    // Called at a falling edge; presents one request for the accepting rising edge.
    task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                                 input logic sgn, input logic [31:0] wdata);
        reqWrite  = wr;
        reqAddr   = addr;
        reqSize   = size;
        reqSigned = sgn;
        reqWdata  = wdata;
        reqValid  = 1'b1;
        checkOutput("req_ready_before_accept", 32'(reqReady), 32'd1);
        @(posedge clk);
        @(negedge clk);
        reqValid  = 1'b0;
    endtask

    task automatic runLoad(input string tag, input logic [31:0] addr, input logic [1:0] size,
                           input logic sgn, input logic [31:0] rdata,
                           input logic [31:0] expAddr, input logic [3:0] expBe, input logic [31:0] expData);
        readdata    = rdata;
        waitrequest = 1'b0;
        applyStimulus(1'b0, addr, size, sgn, 32'h0);
        checkOutput({tag, "_read"}, 32'(read), 32'd1);
        checkOutput({tag, "_write"}, 32'(write), 32'd0);
        checkOutput({tag, "_address"}, address, expAddr);
        checkOutput({tag, "_byteenable"}, 32'(byteenable), 32'(expBe));
        checkOutput({tag, "_resp_valid_early"}, 32'(respValid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput({tag, "_resp_valid"}, 32'(respValid), 32'd1);
        checkOutput({tag, "_resp_err"}, 32'(respErr), 32'd0);
        checkOutput({tag, "_resp_data"}, respData, expData);
        checkOutput({tag, "_read_after"}, 32'(read), 32'd0);
        checkOutput({tag, "_be_after"}, 32'(byteenable), 32'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput({tag, "_resp_valid_drop"}, 32'(respValid), 32'd0);
        checkOutput({tag, "_ready_again"}, 32'(reqReady), 32'd1);
        checkOutput({tag, "_resp_data_held"}, respData, expData);
    endtask

    task automatic runMisaligned(input string tag, input logic [31:0] addr, input logic [1:0] size);
        waitrequest = 1'b0;
        applyStimulus(1'b0, addr, size, 1'b0, 32'h0);
        checkOutput({tag, "_no_read"}, 32'(read), 32'd0);
        checkOutput({tag, "_be_zero"}, 32'(byteenable), 32'd0);
        checkOutput({tag, "_resp_valid"}, 32'(respValid), 32'd1);
        checkOutput({tag, "_resp_err"}, 32'(respErr), 32'd1);
        checkOutput({tag, "_resp_data"}, respData, 32'h0);
        @(posedge clk);
        @(negedge clk);
        checkOutput({tag, "_resp_valid_drop"}, 32'(respValid), 32'd0);
        checkOutput({tag, "_ready_again"}, 32'(reqReady), 32'd1);
    endtask

    initial begin
        checkCount  = 0;
        errorCount  = 0;
        reset       = 1'b0;
        reqValid    = 1'b0;
        reqWrite    = 1'b0;
        reqAddr     = 32'h0;
        reqSize     = 2'b00;
        reqSigned   = 1'b0;
        reqWdata    = 32'h0;
        waitrequest = 1'b0;
        readdata    = 32'h0;

        repeat (2) @(negedge clk);
        checkOutput("rst_read", 32'(read), 32'd0);
        checkOutput("rst_write", 32'(write), 32'd0);
        checkOutput("rst_be", 32'(byteenable), 32'd0);
        checkOutput("rst_address", address, 32'h0);
        checkOutput("rst_writedata", writedata, 32'h0);
        checkOutput("rst_resp_valid", 32'(respValid), 32'd0);
        checkOutput("rst_resp_err", 32'(respErr), 32'd0);
        checkOutput("rst_resp_data", respData, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rst_ready", 32'(reqReady), 32'd1);

        runLoad("word_load", 32'h0000_0104, 2'b10, 1'b0, 32'hDEAD_BEEF, 32'h0000_0104, 4'b1111, 32'hDEAD_BEEF);
        runLoad("sbyte_load", 32'h0000_0103, 2'b00, 1'b1, 32'h80FF_FFFF, 32'h0000_0100, 4'b1000, 32'hFFFF_FF80);
        runLoad("ubyte_load", 32'h0000_0103, 2'b00, 1'b0, 32'h80FF_FFFF, 32'h0000_0100, 4'b1000, 32'h0000_0080);
        runLoad("shalf_load", 32'h0000_0202, 2'b01, 1'b1, 32'h9ABC_1234, 32'h0000_0200, 4'b1100, 32'hFFFF_9ABC);
        runLoad("uhalf_load", 32'h0000_0200, 2'b01, 1'b0, 32'h9ABC_F234, 32'h0000_0200, 4'b0011, 32'h0000_F234);
        runLoad("byte1_load", 32'h0000_0301, 2'b00, 1'b1, 32'h1122_7F44, 32'h0000_0300, 4'b0010, 32'h0000_007F);

        // Half store with three wait-state cycles; a stray request during BUS must be ignored.
        waitrequest = 1'b1;
        applyStimulus(1'b1, 32'h0000_0202, 2'b01, 1'b0, 32'h1234_ABCD);
        for (int i = 0; i < 4; i++) begin
            if (i == 0) begin
                reqValid = 1'b1;
                reqWrite = 1'b0;
                reqAddr  = 32'h0000_0500;
                reqSize  = 2'b10;
            end
            checkOutput("hstore_write", 32'(write), 32'd1);
            checkOutput("hstore_read", 32'(read), 32'd0);
            checkOutput("hstore_address", address, 32'h0000_0200);
            checkOutput("hstore_writedata", writedata, 32'hABCD_ABCD);
            checkOutput("hstore_be", 32'(byteenable), 32'h0000_000C);
            checkOutput("hstore_ready_low", 32'(reqReady), 32'd0);
            checkOutput("hstore_no_resp", 32'(respValid), 32'd0);
            if (i == 3) waitrequest = 1'b0;
            @(posedge clk);
            @(negedge clk);
        end
        reqValid = 1'b0;
        checkOutput("hstore_resp_valid", 32'(respValid), 32'd1);
        checkOutput("hstore_resp_data", respData, 32'h0);
        checkOutput("hstore_resp_err", 32'(respErr), 32'd0);
        checkOutput("hstore_write_after", 32'(write), 32'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("hstore_resp_drop", 32'(respValid), 32'd0);
        checkOutput("hstore_not_queued", 32'(read), 32'd0);

        // Byte store replicates the low byte into every lane.
        waitrequest = 1'b0;
        applyStimulus(1'b1, 32'h0000_0401, 2'b00, 1'b0, 32'hFFFF_FF5A);
        checkOutput("bstore_writedata", writedata, 32'h5A5A_5A5A);
        checkOutput("bstore_be", 32'(byteenable), 32'h0000_0002);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end

        runMisaligned("mis_word", 32'h0000_0101, 2'b10);
        runMisaligned("mis_half", 32'h0000_0203, 2'b01);
        runMisaligned("rsvd_size", 32'h0000_0100, 2'b11);

        // Reset asserted while the bus is stalled.
        waitrequest = 1'b1;
        applyStimulus(1'b0, 32'h0000_0300, 2'b10, 1'b0, 32'h0);
        checkOutput("midrst_read_before", 32'(read), 32'd1);
        #2 reset = 1'b0;
        #1;
        checkOutput("midrst_read", 32'(read), 32'd0);
        checkOutput("midrst_be", 32'(byteenable), 32'd0);
        checkOutput("midrst_address", address, 32'h0);
        checkOutput("midrst_ready", 32'(reqReady), 32'd1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("midrst_no_resp", 32'(respValid), 32'd0);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midrst_no_resp_after", 32'(respValid), 32'd0);
        runLoad("post_rst_load", 32'h0000_0104, 2'b10, 1'b0, 32'h1234_5678, 32'h0000_0104, 4'b1111, 32'h1234_5678);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/bus_interface.md
BUS_INTERFACE -- requirements
Module: bus_interface

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port req_valid, input, 1, the CPU control FSM requests a memory access.
REQ-004 SHALL have port req_write, input, 1, 1=store, 0=load.
REQ-005 SHALL have port req_addr, input, 32, byte address.
REQ-006 SHALL have port req_size, input, 2, 00=byte, 01=half, 10=word, 11=reserved.
REQ-007 SHALL have port req_signed, input, 1, sign-extend a sub-word load.
REQ-008 SHALL have port req_wdata, input, 32, store data, right-aligned.
REQ-009 SHALL have port req_ready, output, 1, request is accepted this cycle.
REQ-010 SHALL have port resp_valid, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port resp_data, output, 32, load result, which drives the data register write input.
REQ-012 SHALL have port resp_err, output, 1, misaligned or reserved-size access; valid with resp_valid.
REQ-013 SHALL have ports address (32), read (1), write (1), byteenable (4) and writedata (32) as outputs, plus waitrequest (1) and readdata (32) as inputs, forming the Avalon-MM master.

Function
REQ-014 SHALL implement FSM states IDLE, BUS, RESP.
REQ-015 SHALL drive req_ready=1 only in IDLE; a request is accepted when req_valid&&req_ready, and all req_* fields are registered at acceptance.
REQ-016 SHALL define misaligned as: half with addr[0]=1, word with addr[1:0]!=0, or size=11.
REQ-017 SHALL, on an aligned accept, go IDLE->BUS; on a misaligned accept, go IDLE->RESP with resp_err=1, resp_data=0, and no bus cycle.
REQ-018 SHALL, in BUS, drive address={addr[31:2],2'b00} and assert read or write, holding every bus output stable while waitrequest=1.
REQ-019 SHALL complete in the first BUS cycle with waitrequest=0, capture readdata, and go to RESP.
REQ-020 SHALL, in RESP, pulse resp_valid for exactly one cycle and then return to IDLE; the minimum latency is accept at cycle N, bus at N+1, resp_valid at N+2.
REQ-021 SHALL use little-endian lanes: byte offset k maps to bits 8k+7:8k; byteenable is 0001<<a[1:0] for byte, 0011<<a[1:0] for half, and 1111 for word.
REQ-022 SHALL replicate writedata as byte x4 or half x2, and pass words unchanged.
REQ-023 SHALL shift the selected load lane to bit 0 and zero-extend it, or sign-extend it when req_signed=1; a word is returned unchanged.
REQ-024 SHALL hold resp_data until the next completion, and return 0 for stores.
REQ-025 SHALL drive read=write=0 and byteenable=0 outside BUS.
REQ-026 SHALL ignore req_valid outside IDLE; no request queueing is provided.

Reset
REQ-027 SHALL, on reset=0 at any time including mid-bus, immediately force IDLE, read=write=0, byteenable=0, address=0, writedata=0, resp_valid=0, resp_err=0, resp_data=0, with req_ready=1 after deassertion.
REQ-028 SHALL resume normal operation on the first rising clk edge after reset deassertion.

Structure
REQ-029 SHALL place the size encoding (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state enum in shared package mips_bus_pkg.
REQ-030 SHALL implement lane steering and extension in one combinational sub-module, byte_lane_align, instanced twice (store steering, load extraction).

Verification
REQ-031 Word load at 0x00000104 with readdata=0xDEADBEEF and zero wait states -> resp_valid at accept+2, resp_data=0xDEADBEEF, byteenable=1111.
REQ-032 Signed byte load at 0x103 with readdata=0x80FFFFFF -> byteenable=1000, resp_data=0xFFFFFF80; the unsigned case gives 0x00000080.
REQ-033 Half store 0x1234ABCD at 0x202 with waitrequest=1 for 3 cycles -> writedata=0xABCDABCD, byteenable=1100, bus outputs stable for 4 cycles, resp_valid one cycle later.
REQ-034 Word load at 0x101 -> no read asserted, resp_valid=1 and resp_err=1 at accept+1, resp_data=0.
REQ-035 Reset pulled low during a BUS cycle with waitrequest=1 -> read=0 within the same cycle, state IDLE, resp_valid never pulses; a following word load completes normally.
